// File: rtl/fetch_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the fetch unit and its branch LUT.
// Revision : 1.0 - initial release
// =============================================================================
package fetch_pkg;

    localparam int ADDR_W    = 10;
    localparam int INST_W    = 9;
    localparam int LUT_DEPTH = 8;
    localparam int SEL_W     = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [INST_W-1:0] HALT_WORD = {INST_W{1'b1}};

    // Entry i holds 64*i; element 0 sits at the least significant slice.
    localparam logic [LUT_DEPTH-1:0][ADDR_W-1:0] BRANCH_TARGETS = {
        10'd448, 10'd384, 10'd320, 10'd256,
        10'd192, 10'd128, 10'd64,  10'd0
    };

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit_if
// Purpose  : Fetch-side bundle: control inputs, ROM word, address and status.
// Revision : 1.0 - initial release
// =============================================================================
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int A = ADDR_W,
    parameter int W = INST_W
) ();

    logic             Start;
    logic             Stall;
    logic             BranchEn;
    logic [SEL_W-1:0] TargetSel;
    logic [W-1:0]     InstIn;
    logic [A-1:0]     InstAddress;
    logic             InstValid;
    logic             Done;
    logic [15:0]      CycleCount;

    modport master (
        input  Start, Stall, BranchEn, TargetSel, InstIn,
        output InstAddress, InstValid, Done, CycleCount
    );

    modport slave (
        output Start, Stall, BranchEn, TargetSel, InstIn,
        input  InstAddress, InstValid, Done, CycleCount
    );

endinterface
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// =============================================================================
// Module   : branch_lut
// Purpose  : Combinational map from branch target index to absolute address.
// Revision : 1.0 - initial release
// =============================================================================
module branch_lut
    import fetch_pkg::*;
#(
    parameter int A = ADDR_W
) (
    input  wire logic [SEL_W-1:0] sel_i,
    output logic      [A-1:0]     target_o
);

    assign target_o = A'(BRANCH_TARGETS[sel_i]);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit
// Purpose  : PC register, IDLE/RUN/HALT sequencer and absolute-branch fetch.
//            Define FETCH_CYCLE_COUNT_EN to build the executed-cycle counter.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int A = ADDR_W,
    parameter int W = INST_W
) (
    input  wire logic    Clk,
    input  wire logic    Reset,
    fetch_unit_if.master bus
);

    fetch_state_t state_q;
    logic [A-1:0] pc_q;
    logic [A-1:0] pc_d;
    logic         done_q;
    logic [A-1:0] w_target;
    logic         w_is_halt;
    logic         w_advance;

    branch_lut #(.A(A)) u_branch_lut (
        .sel_i    (bus.TargetSel),
        .target_o (w_target)
    );

    assign w_is_halt = (bus.InstIn == {W{1'b1}});
    assign w_advance = (state_q == RUN) && !bus.Stall;

    always_comb begin
        pc_d = pc_q + A'(1);
        if (bus.BranchEn) begin
            pc_d = w_target;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                    end
                end
                RUN: begin
                    // The halt word wins over a branch; the PC stays on it.
                    if (!bus.Stall) begin
                        if (w_is_halt) begin
                            state_q <= HALT;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                HALT: begin
                    if (bus.Start) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pc_q    <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.Done        = done_q;
    assign bus.InstValid   = w_advance && !w_is_halt;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (bus.Start && (state_q != RUN)) begin
            cnt_q <= '0;
        end else if (w_advance && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.CycleCount = cnt_q;
`else
    assign bus.CycleCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a behavioural ROM.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] rom [1024];
    logic [9:0] exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;

`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    fetch_unit_if bus ();

    fetch_unit dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    assign bus.InstIn = rom[bus.InstAddress];

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_cnt(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    // Advance one edge and compare the address against the oldest expectation.
    task automatic tick(input string name);
        logic [9:0] e;
        @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, InstAddress=%0d", name, bus.InstAddress);
        end else begin
            e = exp_q.pop_front();
            if (bus.InstAddress !== e) begin
                n_fail++;
                $display("FAIL %s: InstAddress=%0d expected %0d", name, bus.InstAddress, e);
            end
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.Start = 1'b1;
        exp_q.push_back(10'd0);
        tick("restart");
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (bus.InstAddress !== 10'd0 || bus.Done !== 1'b0 || bus.InstValid !== 1'b0 ||
            bus.CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: addr=%0d done=%b valid=%b cnt=%0d expected 0/0/0/0",
                     bus.InstAddress, bus.Done, bus.InstValid, bus.CycleCount);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.push_back(10'd0);
        tick("idle_hold");
        n_tests++;
        if (bus.InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: InstValid=%b expected 0", bus.InstValid);
        end
    endtask

    task automatic test_sequence_and_branch();
        bus.Start = 1'b1;
        exp_q.push_back(10'd0);
        tick("start");
        bus.Start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            n_tests++;
            if (bus.InstValid !== 1'b1 || bus.Done !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_valid: valid=%b done=%b expected 1/0", bus.InstValid, bus.Done);
            end
            exp_q.push_back(10'(i));
            tick("seq");
        end
        bus.BranchEn  = 1'b1;
        bus.TargetSel = 3'd3;
        exp_q.push_back(10'd192);
        tick("branch");
        bus.BranchEn = 1'b0;
        exp_q.push_back(10'd193);
        tick("after_branch");
        bus.Start = 1'b1;
        exp_q.push_back(10'd194);
        tick("start_in_run");
        bus.Start = 1'b0;
    endtask

    task automatic test_stall();
        restart();
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back(10'(i));
            tick("to_pc7");
        end
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus.InstValid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_valid: InstValid=%b expected 0", bus.InstValid);
            end
            exp_q.push_back(10'd7);
            tick("stall");
            n_tests++;
            if (bus.CycleCount !== exp_cnt(7)) begin
                n_fail++;
                $display("FAIL stall_cnt: CycleCount=%0d expected %0d", bus.CycleCount, exp_cnt(7));
            end
        end
        bus.Stall = 1'b0;
        exp_q.push_back(10'd8);
        tick("unstall");
        n_tests++;
        if (bus.CycleCount !== exp_cnt(8)) begin
            n_fail++;
            $display("FAIL unstall_cnt: CycleCount=%0d expected %0d", bus.CycleCount, exp_cnt(8));
        end
    endtask

    task automatic test_halt();
        rom[4] = 9'h1FF;
        restart();
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(10'(i));
            tick("to_halt");
        end
        // Branch request on the halt word must be ignored.
        bus.BranchEn  = 1'b1;
        bus.TargetSel = 3'd2;
        #1;
        n_tests++;
        if (bus.InstValid !== 1'b0 || bus.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_word: valid=%b done=%b expected 0/0", bus.InstValid, bus.Done);
        end
        exp_q.push_back(10'd4);
        tick("halt_edge");
        bus.BranchEn = 1'b0;
        n_tests++;
        if (bus.Done !== 1'b1 || bus.CycleCount !== exp_cnt(5)) begin
            n_fail++;
            $display("FAIL halt_done: done=%b cnt=%0d expected 1/%0d",
                     bus.Done, bus.CycleCount, exp_cnt(5));
        end
        bus.Stall = 1'b1;
        exp_q.push_back(10'd4);
        tick("halt_frozen");
        bus.Stall = 1'b0;
        exp_q.push_back(10'd4);
        tick("halt_frozen2");
        bus.Start = 1'b1;
        exp_q.push_back(10'd0);
        tick("halt_restart");
        bus.Start = 1'b0;
        n_tests++;
        if (bus.Done !== 1'b0 || bus.InstValid !== 1'b1 || bus.CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL halt_restart_state: done=%b valid=%b cnt=%0d expected 0/1/0",
                     bus.Done, bus.InstValid, bus.CycleCount);
        end
        rom[4] = 9'h000;
    endtask

    task automatic test_wrap();
        restart();
        bus.BranchEn  = 1'b1;
        bus.TargetSel = 3'd7;
        exp_q.push_back(10'd448);
        tick("branch7");
        bus.BranchEn = 1'b0;
        for (int a = 449; a <= 1023; a++) begin
            exp_q.push_back(10'(a));
            tick("climb");
        end
        exp_q.push_back(10'd0);
        tick("wrap");
        exp_q.push_back(10'd1);
        tick("post_wrap");
    endtask

    task automatic test_async_reset();
        restart();
        for (int i = 1; i <= 12; i++) begin
            exp_q.push_back(10'(i));
            tick("to_pc12");
        end
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.InstAddress !== 10'd0 || bus.Done !== 1'b0 || bus.InstValid !== 1'b0 ||
            bus.CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%0d done=%b valid=%b cnt=%0d expected 0/0/0/0",
                     bus.InstAddress, bus.Done, bus.InstValid, bus.CycleCount);
        end
        #1;
        rst = 1'b0;
        exp_q.push_back(10'd0);
        tick("reset_idle");
        exp_q.push_back(10'd0);
        tick("reset_idle2");
        n_tests++;
        if (bus.InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_needs_start: InstValid=%b expected 0", bus.InstValid);
        end
        bus.Start = 1'b1;
        exp_q.push_back(10'd0);
        tick("resume");
        bus.Start = 1'b0;
        exp_q.push_back(10'd1);
        tick("resume_step");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.Stall     = 1'b0;
        bus.BranchEn  = 1'b0;
        bus.TargetSel = 3'd0;

        test_reset();
        test_sequence_and_branch();
        test_stall();
        test_halt();
        test_wrap();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the basic processor. It drives the instruction address into the combinational instruction ROM and receives the fetched word back in the same cycle. It also resolves absolute branches through an 8-entry target lookup table, detects the halt word, and runs the Start/Done handshake with the test bench. It sits directly upstream of the instruction ROM and feeds the decoder.

## Interface
- `A`, 10: instruction address width; program counter range is 0 .. 2**A-1.
- `W`, 9: instruction word width.
- `Clk` input 1: sole clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Start` input 1: single-cycle request to begin, or restart, execution at address 0.
- `Stall` input 1: holds the PC and all state for the cycle; it is ignored outside RUN.
- `BranchEn` input 1: from the decoder; when high, the current instruction is a taken branch.
- `TargetSel` input 3: branch LUT index, valid when `BranchEn` is high.
- `InstIn` input W: word returned by the ROM for the current `InstAddress`.
- `InstAddress` output A: registered PC, wired to the ROM address.
- `InstValid` output 1: `InstIn` is a live instruction the decoder must execute this cycle.
- `Done` output 1: the program has halted.
- `CycleCount` output 16: executed-cycle counter; see Configuration.

## Operation
- States: IDLE, RUN, HALT.
  - Reset forces IDLE, PC=0, `Done`=0, `InstValid`=0, `CycleCount`=0.
- IDLE:
  - `Start`=1 moves to RUN with PC=0.
  - Otherwise the block stays in IDLE.
- RUN, with the following priority per cycle:
  1. `Stall`=1: hold everything. `InstValid` is 0.
  2. `InstIn` equals all ones (the halt word): move to HALT. The PC holds the halt address. `BranchEn` is ignored.
  3. `BranchEn`=1: PC ← LUT[`TargetSel`].
  4. Otherwise: PC ← PC+1, modulo 2**A. Address 1023 wraps to 0 with no error.
- `Start` is ignored while in RUN.
- HALT:
  - `Done`=1 and the PC is frozen.
  - `Start`=1 returns to RUN with PC=0 and clears `Done` on that edge.
  - `Stall` is ignored.
- `InstValid` = (state==RUN) && !`Stall` && (`InstIn` != all ones). It is combinational from state and inputs.
- Branch LUT contents are fixed constants: entry i = 64·i, zero-extended to A bits, giving 0, 64, 128, … 448.

## Timing
- `InstAddress` is a register output; it changes only on a `Clk` edge or on `Reset` assertion.
- The ROM is combinational, so `InstIn` for address N is sampled in the same cycle that `InstAddress`=N.
- A branch resolves with zero bubbles: the target address appears on the edge after `BranchEn` is sampled.
- Start to first fetch: `Start` is high at edge k, RUN begins and address 0 is presented from edge k. The first `InstValid` occurs in the cycle after edge k.
- Halt to Done: the halt word is seen at edge k, and `Done`=1 from edge k.
- `Done` deasserts on the edge that samples `Start` in HALT.
- Reset asserted mid-RUN takes effect immediately and asynchronously. All outputs return to their reset values without waiting for an edge.
- Reset release is assumed synchronous to `Clk` by the environment.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined:
  - `CycleCount` increments on every RUN cycle with `Stall`=0, including the halt cycle.
  - The count saturates at 16'hFFFF.
  - It clears to 0 on `Start` and on reset, and holds in IDLE and HALT.
- Not defined: `CycleCount` is tied to 0 and no counter flops are synthesized. The port remains present.

## Structure
- Package `fetch_pkg` contains:
  - state enum `fetch_state_t` {IDLE, RUN, HALT};
  - `HALT_WORD` (all ones, W bits);
  - `LUT_DEPTH`=8;
  - the branch target constant array.
- Sub-module `branch_lut`: a combinational 3-bit-index to A-bit-target map read from `fetch_pkg`.
- The PC register, FSM, and optional counter live in `fetch_unit`.

## Test plan
- Reset then `Start` pulse, with ROM words at 0..3 being non-halt and not branching:
  - `InstAddress` sequence is 0, 1, 2, 3;
  - `InstValid`=1 each cycle;
  - `Done`=0.
- `BranchEn`=1 with `TargetSel`=3 at PC=5:
  - next `InstAddress`=192, then 193.
- `Stall` held for 3 cycles at PC=7:
  - `InstAddress` stays 7 for 3 cycles;
  - `InstValid`=0 during the stall;
  - `CycleCount` unchanged (macro defined).
- ROM word 9'h1FF at address 4:
  - HALT entered, `Done`=1, `InstAddress` frozen at 4;
  - a later `Start` gives `InstAddress`=0 and `Done`=0.
- PC at 1023 with no branch:
  - next `InstAddress`=0.
- `Reset` asserted mid-RUN at PC=12, between edges:
  - `InstAddress`=0, `Done`=0, state IDLE, all before the next edge;
  - `Start` is required to resume.
